// File: rtl/two_four_divider.sv
// Fixed divide-by-2 / divide-by-4 divider. A 2-bit up-counter clocked by cp,
// with a synchronous active-low reset. Q0 carries the /2 output and Q1 the /4 output.
module two_four_divider (
   input  logic cp,
   input  logic rst,
   output logic Q1,
   output logic Q0
);

   // The declaration value is the power-up state of the flops. The logic
   // itself never relies on it, because rst brings the counter to 00.
   logic [1:0] count = 2'b00;

   // NOTE: rst is only sampled inside the clocked process, so the reset is
   // synchronous. Non-blocking assignments ensure both bits use the pre-edge count.
   always_ff @(posedge cp) begin
      if (!rst) begin
         count <= 2'b00;
      end else begin
         count[0] <= ~count[0];
         count[1] <= count[1] ^ count[0];
      end
   end

   // Both outputs come straight from the register, so no input reaches them combinationally.
   assign Q1 = count[1];
   assign Q0 = count[0];

endmodule

// File: tb/tb_two_four_divider.sv
// Directed testbench for two_four_divider. Each expected {Q1,Q0} value is worked
// out by hand from the counting rule. Outputs are sampled on the falling edge of cp.
module tb_two_four_divider;

   logic cp;
   logic rst;
   logic Q1;
   logic Q0;

   int vectors     = 0;
   int miscompares = 0;

   two_four_divider dut (
      .cp  (cp),
      .rst (rst),
      .Q1  (Q1),
      .Q0  (Q0)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic check(input string tag, input logic [1:0] expected);
      vectors++;
      assert ({Q1, Q0} === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b, expected %b", tag, {Q1, Q0}, expected);
      end
   endtask

   // Wait one rising edge, then sample on the following falling edge.
   task automatic step(input string tag, input logic [1:0] expected);
      @(posedge cp);
      @(negedge cp);
      check(tag, expected);
   endtask

   initial begin
      rst = 1'b0;

      // reset hold
      step("reset_hold_0", 2'b00);
      step("reset_hold_1", 2'b00);

      // count: the first edge after release gives 01
      rst = 1'b1;
      step("count_01", 2'b01);
      step("count_10", 2'b10);
      step("count_11", 2'b11);
      step("count_wrap_00", 2'b00);

      // wrap and period: the same sequence twice, starting from 00
      step("period_a_01", 2'b01);
      step("period_a_10", 2'b10);
      step("period_a_11", 2'b11);
      step("period_a_00", 2'b00);
      step("period_b_01", 2'b01);
      step("period_b_10", 2'b10);
      step("period_b_11", 2'b11);
      step("period_b_00", 2'b00);

      // mid-sequence reset from 11, then hold at 00
      step("mid_pre_01", 2'b01);
      step("mid_pre_10", 2'b10);
      step("mid_pre_11", 2'b11);
      rst = 1'b0;
      step("mid_reset_from_11", 2'b00);
      step("mid_reset_hold", 2'b00);

      // release
      rst = 1'b1;
      step("release_01", 2'b01);
      step("release_10", 2'b10);

      // mid-sequence reset from 10
      rst = 1'b0;
      step("mid_reset_from_10", 2'b00);

      // mid-sequence reset from 01
      rst = 1'b1;
      step("rerelease_01", 2'b01);
      rst = 1'b0;
      step("mid_reset_from_01", 2'b00);

      // async immunity: pulse rst low between two edges while counting at 10
      rst = 1'b1;
      step("imm_pre_01", 2'b01);
      step("imm_pre_10", 2'b10);
      #1 rst = 1'b0;
      #2 rst = 1'b1;
      check("imm_between_edges", 2'b10);
      step("imm_after_11", 2'b11);
      step("imm_after_00", 2'b00);
      step("imm_after_01", 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
